fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
- Instruction-fetch stage directly upstream of the instruction memory; the stage owns the program counter.
- Drives the memory's byte-address PC input and samples the 32-bit instruction, which returns combinationally in the same cycle.
- Registers the instruction into the IF/ID pipeline register that feeds decode.
- Supports decode back-pressure (stall), branch/jump redirect (flush), and a halt at the end of instruction memory.

Parameters:
- MEM_SIZE, 256: instruction memory depth in entries. The memory is indexed directly by the byte PC, so the last legal PC is MEM_SIZE-4.
- RESET_PC, 32'h0000_0000: PC value loaded on reset.

Ports:
- clk  input  1  system clock, rising-edge.
- resetN  input  1  asynchronous, active-low reset.
- imem_addr  output  32  PC presented to instruction memory; equals the internal pc register.
- imem_data  input  32  instruction returned combinationally for imem_addr.
- stall  input  1  decode not ready; hold the PC and IF/ID contents.
- redirect_valid  input  1  branch/jump taken this cycle.
- redirect_target  input  32  new PC when redirect_valid=1.
- if_id_valid  output  1  IF/ID register holds a live instruction.
- if_id_instr  output  32  fetched instruction.
- if_id_pc  output  32  PC of if_id_instr.
- if_id_pc_plus4  output  32  if_id_pc+4, for link/branch arithmetic.
- halted  output  1  high while in the HALTED state.
- misalign_err  output  1  sticky flag; set when redirect_target[1:0] != 0.
- fetch_count  output  32  number of instructions captured into IF/ID since reset.

Behaviour:
- Reset (asynchronous assert; deassert synchronous to clk):
  - pc=RESET_PC, state=IDLE.
  - if_id_valid=0, if_id_instr=0, if_id_pc=0, if_id_pc_plus4=0.
  - halted=0, misalign_err=0, fetch_count=0.
- States: IDLE, RUN, HALTED.
- IDLE:
  - Exactly one post-reset bubble cycle; no capture, PC held.
  - Next state is RUN unconditionally.
  - A redirect in IDLE is ignored.
- RUN priority per cycle is redirect > stall > normal fetch.
  - Redirect:
    - pc <= {redirect_target[31:2],2'b00}.
    - Flush: if_id_valid<=0, if_id_instr<=0.
    - fetch_count unchanged.
    - misalign_err<=1 if redirect_target[1:0]!=0.
    - Redirect overrides a simultaneous stall.
  - Stall (no redirect): pc and all IF/ID outputs hold their values.
  - Normal fetch:
    - if_id_instr<=imem_data, if_id_pc<=pc, if_id_pc_plus4<=pc+4, if_id_valid<=1.
    - fetch_count<=fetch_count+1.
    - If pc==MEM_SIZE-4: pc holds and state<=HALTED. Otherwise pc<=pc+4.
- HALTED:
  - halted=1. The last instruction remains valid until it is consumed.
  - First non-stalled cycle: if_id_valid<=0.
  - Redirect: state<=RUN, pc<=target, IF/ID flushed, halted deasserts in the next cycle.
- Fetch latency: instruction at PC appears on if_id_* one clock after imem_addr=PC with stall=0.
- Arithmetic:
  - PC increments are 32-bit unsigned.
  - pc never wraps past MEM_SIZE-4 because of the halt.
  - A redirect target ≥ MEM_SIZE is accepted; the stage halts once it reaches or passes MEM_SIZE-4, with the comparison done as pc >= MEM_SIZE-4.
  - fetch_count wraps modulo 2^32.
- Reset mid-operation: all state returns to reset values immediately; no partial IF/ID update.

Decomposition:
- Shared package mips_pkg:
  - typedef fetch_state_t (IDLE/RUN/HALTED).
  - constants INSTR_W=32, PC_STEP=4.
  - typedef if_id_t struct {valid, instr, pc, pc_plus4} for reuse by decode.
- Sub-module if_id_reg: the pipeline register, with load/flush/hold controls. The PC/FSM logic stays in fetch_unit.

Test Plan:
- Reset with imem holding 0x20110001@0, 0x2012000A@4, 0x02329820@8; no stall → IDLE bubble, then if_id_instr = 0x20110001, 0x2012000A, 0x02329820 on consecutive cycles; if_id_pc = 0, 4, 8; fetch_count = 3.
- Stall asserted for 3 cycles while if_id_pc=4 → imem_addr stays 8 and if_id_* unchanged; after release, the next capture is pc=8.
- Redirect to 0x40 while stall=1 and if_id_valid=1 → next cycle if_id_valid=0, imem_addr=0x40; the following cycle if_id_pc=0x40.
- Redirect target 0x42 → pc=0x40, misalign_err=1 and it stays 1 after further fetches.
- MEM_SIZE=16, run from 0 → captures pc 0, 4, 8, 12, then halted=1, imem_addr=12, if_id_valid drops; redirect to 0 → RUN resumes at pc 0.
- Assert resetN=0 mid-stream (pc=0x20, fetch_count=8) → all outputs zero and pc=0 immediately, without waiting for a clk edge.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared fetch/decode types: FSM states, IF/ID payload struct and PC constants.
package mips_pkg;

    localparam int          INSTR_W = 32;
    localparam logic [31:0] PC_STEP = 32'd4;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        HALTED
    } fetch_state_t;

    typedef struct packed {
        logic               valid;
        logic [INSTR_W-1:0] instr;
        logic [31:0]        pc;
        logic [31:0]        pc_plus4;
    } if_id_t;

    // Instruction memory is word-aligned; low address bits are discarded.
    function automatic logic [31:0] align_pc(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register. Priority: flush > load > drop (clear valid only) > hold.
module if_id_reg
    import mips_pkg::*;
(
    input  logic   clk,
    input  logic   resetN,
    input  logic   load,
    input  logic   flush,
    input  logic   drop,
    input  if_id_t next,
    output if_id_t q
);

    // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            q <= '0;
        end else if (flush) begin
            q.valid <= 1'b0;
            q.instr <= '0;
        end else if (load) begin
            q <= next;
        end else if (drop) begin
            q.valid <= 1'b0;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, drives instruction memory and fills IF/ID.
module fetch_unit
    import mips_pkg::*;
#(
    parameter int          MEM_SIZE = 256,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic               clk,
    input  logic               resetN,
    output logic [31:0]        imem_addr,
    input  logic [INSTR_W-1:0] imem_data,
    input  logic               stall,
    input  logic               redirect_valid,
    input  logic [31:0]        redirect_target,
    output logic               if_id_valid,
    output logic [INSTR_W-1:0] if_id_instr,
    output logic [31:0]        if_id_pc,
    output logic [31:0]        if_id_pc_plus4,
    output logic               halted,
    output logic               misalign_err,
    output logic [31:0]        fetch_count
);

    localparam logic [31:0] LAST_PC = 32'(MEM_SIZE - 4);

    fetch_state_t state;
    logic [31:0]  pc;
    logic         rf_load;
    logic         rf_flush;
    logic         rf_drop;
    if_id_t       rf_next;
    if_id_t       rf_q;

    assign imem_addr = pc;

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        rf_load  = 1'b0;
        rf_flush = 1'b0;
        rf_drop  = 1'b0;
        unique case (state)
            RUN: begin
                if (redirect_valid)  rf_flush = 1'b1;
                else if (!stall)     rf_load  = 1'b1;
            end
            HALTED: begin
                if (redirect_valid)  rf_flush = 1'b1;
                else if (!stall)     rf_drop  = 1'b1;
            end
            default: ;
        endcase
    end

    assign rf_next = '{valid: 1'b1, instr: imem_data, pc: pc, pc_plus4: pc + PC_STEP};

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state        <= IDLE;
            pc           <= RESET_PC;
            halted       <= 1'b0;
            misalign_err <= 1'b0;
            fetch_count  <= '0;
        end else begin
            unique case (state)
                IDLE: state <= RUN;
                RUN: begin
                    if (redirect_valid) begin
                        pc <= align_pc(redirect_target);
                        if (redirect_target[1:0] != 2'b00) misalign_err <= 1'b1;
                    end else if (!stall) begin
                        fetch_count <= fetch_count + 32'd1;
                        // >= also catches redirect targets that land beyond the memory.
                        if (pc >= LAST_PC) begin
                            state  <= HALTED;
                            halted <= 1'b1;
                        end else begin
                            pc <= pc + PC_STEP;
                        end
                    end
                end
                HALTED: begin
                    if (redirect_valid) begin
                        state  <= RUN;
                        halted <= 1'b0;
                        pc     <= align_pc(redirect_target);
                        if (redirect_target[1:0] != 2'b00) misalign_err <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    if_id_reg u_if_id_reg (
        .clk    (clk),
        .resetN (resetN),
        .load   (rf_load),
        .flush  (rf_flush),
        .drop   (rf_drop),
        .next   (rf_next),
        .q      (rf_q)
    );

    assign if_id_valid    = rf_q.valid;
    assign if_id_instr    = rf_q.instr;
    assign if_id_pc       = rf_q.pc;
    assign if_id_pc_plus4 = rf_q.pc_plus4;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a 256-entry instance for fetch/stall/redirect/reset, a 16-entry one for halt.
module tb_fetch_unit;

    logic        clk = 1'b0;
    int          checks = 0;
    int          failures = 0;

    // Instance A (MEM_SIZE=256)
    logic        rst_a = 1'b0;
    logic [31:0] addr_a, data_a;
    logic        stall_a = 1'b0, redir_a = 1'b0;
    logic [31:0] target_a = '0;
    logic        valid_a, halted_a, mis_a;
    logic [31:0] instr_a, pc_a, pc4_a, cnt_a;

    // Instance B (MEM_SIZE=16)
    logic        rst_b = 1'b0;
    logic [31:0] addr_b, data_b;
    logic        stall_b = 1'b0, redir_b = 1'b0;
    logic [31:0] target_b = '0;
    logic        valid_b, halted_b, mis_b;
    logic [31:0] instr_b, pc_b, pc4_b, cnt_b;

    always #5 clk = ~clk;

    function automatic logic [31:0] imem(input logic [31:0] a);
        case (a)
            32'h0:   return 32'h2011_0001;
            32'h4:   return 32'h2012_000A;
            32'h8:   return 32'h0232_9820;
            default: return 32'hA000_0000 | a;
        endcase
    endfunction

    assign data_a = imem(addr_a);
    assign data_b = imem(addr_b);

    fetch_unit #(.MEM_SIZE(256)) dut_a (
        .clk(clk), .resetN(rst_a), .imem_addr(addr_a), .imem_data(data_a),
        .stall(stall_a), .redirect_valid(redir_a), .redirect_target(target_a),
        .if_id_valid(valid_a), .if_id_instr(instr_a), .if_id_pc(pc_a),
        .if_id_pc_plus4(pc4_a), .halted(halted_a), .misalign_err(mis_a),
        .fetch_count(cnt_a)
    );

    fetch_unit #(.MEM_SIZE(16)) dut_b (
        .clk(clk), .resetN(rst_b), .imem_addr(addr_b), .imem_data(data_b),
        .stall(stall_b), .redirect_valid(redir_b), .redirect_target(target_b),
        .if_id_valid(valid_b), .if_id_instr(instr_b), .if_id_pc(pc_b),
        .if_id_pc_plus4(pc4_b), .halted(halted_b), .misalign_err(mis_b),
        .fetch_count(cnt_b)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        // Reset values while resetN is low
        #1;
        check("rst_addr",  addr_a, 32'h0);
        check("rst_valid", 32'(valid_a), 32'h0);
        check("rst_instr", instr_a, 32'h0);
        check("rst_pc4",   pc4_a, 32'h0);
        check("rst_cnt",   cnt_a, 32'h0);
        check("rst_halt",  32'(halted_a), 32'h0);
        #1 rst_a = 1'b1;

        // IDLE bubble, with a redirect that must be ignored
        redir_a = 1'b1; target_a = 32'h80;
        step();
        redir_a = 1'b0;
        check("bubble_valid", 32'(valid_a), 32'h0);
        check("bubble_addr",  addr_a, 32'h0);

        step();
        check("f0_instr", instr_a, 32'h2011_0001);
        check("f0_pc",    pc_a, 32'h0);
        check("f0_pc4",   pc4_a, 32'h4);
        check("f0_valid", 32'(valid_a), 32'h1);
        step();
        check("f1_instr", instr_a, 32'h2012_000A);
        check("f1_pc",    pc_a, 32'h4);

        // Stall for 3 cycles while if_id_pc=4
        stall_a = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("stall_addr",  addr_a, 32'h8);
            check("stall_pc",    pc_a, 32'h4);
            check("stall_instr", instr_a, 32'h2012_000A);
            check("stall_cnt",   cnt_a, 32'h2);
        end
        stall_a = 1'b0;
        step();
        check("f2_instr", instr_a, 32'h0232_9820);
        check("f2_pc",    pc_a, 32'h8);
        check("f2_cnt",   cnt_a, 32'h3);

        step();
        check("f3_pc", pc_a, 32'hC);
        check("f3_cnt", cnt_a, 32'h4);

        // Redirect overrides simultaneous stall
        stall_a = 1'b1; redir_a = 1'b1; target_a = 32'h40;
        step();
        stall_a = 1'b0; redir_a = 1'b0;
        check("redir_valid", 32'(valid_a), 32'h0);
        check("redir_instr", instr_a, 32'h0);
        check("redir_addr",  addr_a, 32'h40);
        check("redir_cnt",   cnt_a, 32'h4);
        step();
        check("post_redir_pc",    pc_a, 32'h40);
        check("post_redir_instr", instr_a, 32'hA000_0040);
        check("post_redir_valid", 32'(valid_a), 32'h1);
        check("mis_clear", 32'(mis_a), 32'h0);

        // Misaligned redirect: aligned PC, sticky error
        redir_a = 1'b1; target_a = 32'h42;
        step();
        redir_a = 1'b0;
        check("mis_addr", addr_a, 32'h40);
        check("mis_set",  32'(mis_a), 32'h1);
        step();
        step();
        check("mis_sticky", 32'(mis_a), 32'h1);
        check("mis_pc",     pc_a, 32'h44);
        check("mis_cnt",    cnt_a, 32'h7);

        redir_a = 1'b1; target_a = 32'h1C;
        step();
        redir_a = 1'b0;
        step();
        check("pre_rst_addr", addr_a, 32'h20);
        check("pre_rst_cnt",  cnt_a, 32'h8);

        // Asynchronous reset mid-cycle, sampled before any clock edge
        #2 rst_a = 1'b0;
        #1;
        check("arst_addr",  addr_a, 32'h0);
        check("arst_valid", 32'(valid_a), 32'h0);
        check("arst_instr", instr_a, 32'h0);
        check("arst_pc",    pc_a, 32'h0);
        check("arst_pc4",   pc4_a, 32'h0);
        check("arst_cnt",   cnt_a, 32'h0);
        check("arst_mis",   32'(mis_a), 32'h0);

        // Instance B: halt at end of a 16-byte memory
        step();
        rst_b = 1'b1;
        step();
        check("b_bubble", 32'(valid_b), 32'h0);
        for (int i = 0; i < 4; i++) begin
            step();
            check("b_cap_pc", pc_b, 32'(4 * i));
        end
        check("b_halted",    32'(halted_b), 32'h1);
        check("b_last_vld",  32'(valid_b), 32'h1);
        check("b_addr_hold", addr_b, 32'hC);
        check("b_cnt",       cnt_b, 32'h4);
        step();
        check("b_drop_vld",  32'(valid_b), 32'h0);
        check("b_drop_halt", 32'(halted_b), 32'h1);
        check("b_drop_addr", addr_b, 32'hC);
        check("b_drop_cnt",  cnt_b, 32'h4);

        redir_b = 1'b1; target_b = 32'h0;
        step();
        redir_b = 1'b0;
        check("b_resume_halt", 32'(halted_b), 32'h0);
        check("b_resume_addr", addr_b, 32'h0);
        step();
        check("b_resume_pc",  pc_b, 32'h0);
        check("b_resume_vld", 32'(valid_b), 32'h1);

        // Target beyond memory: captured once, then halts
        redir_b = 1'b1; target_b = 32'h40;
        step();
        redir_b = 1'b0;
        step();
        check("b_far_pc",   pc_b, 32'h40);
        check("b_far_halt", 32'(halted_b), 32'h1);
        check("b_far_addr", addr_b, 32'h40);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
